// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared types, defaults and helpers for the GCD controller slice
package gcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } gcd_state_t;

   localparam int OP_SZ_DEFAULT = 8;

   // Subtraction budget: any nonzero pair needs at most 2**op_sz-2 steps.
   function automatic int max_iter(input int op_sz);
      return (1 << op_sz) - 1;
   endfunction

endpackage

// File: rtl/gcd_if.sv
// rtl/gcd_if.sv - host/datapath handshake bundle seen by the GCD controller
interface gcd_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic             A_eq_B;
   logic             A_gt_B;
   logic             A_sel;
   logic             B_sel;
   logic             A_ld;
   logic             B_ld;
   logic             out_ld;
   logic             ready;
   logic             busy;
   logic             done;
   logic             err;
   logic [CNT_W-1:0] iter_cnt;

   modport master (
      output start, A_eq_B, A_gt_B,
      input  A_sel, B_sel, A_ld, B_ld, out_ld, ready, busy, done, err, iter_cnt
   );

   modport slave (
      input  start, A_eq_B, A_gt_B,
      output A_sel, B_sel, A_ld, B_ld, out_ld, ready, busy, done, err, iter_cnt
   );
endinterface

// File: rtl/gcd_iter_counter.sv
// rtl/gcd_iter_counter.sv - saturating subtraction counter with limit flag
module gcd_iter_counter #(
   parameter int MAX_ITER = 255,
   parameter int CNT_W    = $clog2(MAX_ITER + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_at_limit
);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_ITER);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != LIMIT)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_cnt      = r_cnt;
   assign o_at_limit = (r_cnt == LIMIT);
endmodule

// File: rtl/gcd_controller.sv
// rtl/gcd_controller.sv - control FSM for the subtract-based GCD FSMD
module gcd_controller
   import gcd_pkg::*;
#(
   parameter int op_sz    = OP_SZ_DEFAULT,
   parameter int MAX_ITER = max_iter(op_sz),
   parameter int CNT_W    = $clog2(MAX_ITER + 1)
) (
   input logic  clk,
   input logic  rst,
   gcd_if.slave bus
);
   gcd_state_t       r_state;
   logic             r_ready;
   logic             r_busy;
   logic             r_done;
   logic             r_err;

   logic             w_accept;
   logic             w_inc;
   logic             w_at_limit;
   logic [CNT_W-1:0] w_cnt;
   logic             w_A_sel;
   logic             w_B_sel;
   logic             w_A_ld;
   logic             w_B_ld;
   logic             w_out_ld;

   gcd_iter_counter #(
      .MAX_ITER (MAX_ITER),
      .CNT_W    (CNT_W)
   ) u_iter_counter (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (w_accept),
      .i_inc      (w_inc),
      .o_cnt      (w_cnt),
      .o_at_limit (w_at_limit)
   );

   // Mealy strobe decode; reset masks everything, including start acceptance.
   always_comb begin
      w_A_sel  = 1'b0;
      w_B_sel  = 1'b0;
      w_A_ld   = 1'b0;
      w_B_ld   = 1'b0;
      w_out_ld = 1'b0;
      w_inc    = 1'b0;
      w_accept = !rst && bus.start && ((r_state == IDLE) || (r_state == ERR));
      if (w_accept) begin
         w_A_ld = 1'b1;
         w_B_ld = 1'b1;
      end else if (!rst && (r_state == RUN)) begin
         if (bus.A_eq_B) begin
            w_out_ld = 1'b1;
         end else if (!w_at_limit) begin
            w_inc = 1'b1;
            if (bus.A_gt_B) begin
               w_A_sel = 1'b1;
               w_A_ld  = 1'b1;
            end else begin
               w_B_sel = 1'b1;
               w_B_ld  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE, ERR: begin
               if (bus.start) begin
                  r_state <= RUN;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
                  r_err   <= 1'b0;
               end
            end
            RUN: begin
               if (bus.A_eq_B) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else if (w_at_limit) begin
                  r_state <= ERR;
                  r_busy  <= 1'b0;
                  r_ready <= 1'b1;
                  r_err   <= 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
               r_err   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.A_sel    = w_A_sel;
   assign bus.B_sel    = w_B_sel;
   assign bus.A_ld     = w_A_ld;
   assign bus.B_ld     = w_B_ld;
   assign bus.out_ld   = w_out_ld;
   assign bus.ready    = r_ready & ~rst;
   assign bus.busy     = r_busy  & ~rst;
   assign bus.done     = r_done  & ~rst;
   assign bus.err      = r_err   & ~rst;
   assign bus.iter_cnt = rst ? '0 : w_cnt;
endmodule

// File: doc/gcd_controller.md
# gcd_controller

Control FSM for the subtract-based GCD FSMD; drives the select/load strobes of `gcd_datapath` from its `A_eq_B`/`A_gt_B` status flags. It provides a start/ready/done handshake to the host and a bounded iteration count. When the count reaches its limit, the run stops with an error, so zero operands cannot hang the unit. `gcd_top` instantiates one controller and one datapath sharing `clk`/`rst` and the same `op_sz`.

## Interface
- `op_sz`, 8: operand width; must match the datapath.
- `MAX_ITER`, 2**op_sz-1: subtraction budget per run. Any nonzero operand pair needs at most 2**op_sz-2 subtractions.
- `CNT_W`, $clog2(MAX_ITER+1): derived; iteration counter width.

Ports (name, direction, width, meaning):
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: host request. Sampled only while `ready`=1. Operands `A`/`B` at the datapath must be valid in the same cycle.
- `A_eq_B`, in, 1: datapath flag, reg_A == reg_B.
- `A_gt_B`, in, 1: datapath flag, reg_A > reg_B.
- `A_sel`, out, 1: 0 selects external A; 1 selects reg_A-reg_B.
- `B_sel`, out, 1: 0 selects external B; 1 selects reg_B-reg_A.
- `A_ld`, out, 1: reg_A load strobe.
- `B_ld`, out, 1: reg_B load strobe.
- `out_ld`, out, 1: result register load strobe.
- `ready`, out, 1: high in IDLE and ERR.
- `busy`, out, 1: high in RUN.
- `done`, out, 1: one-cycle pulse; datapath `res` is valid in this cycle.
- `err`, out, 1: high in ERR; held until next accepted `start` or `rst`.
- `iter_cnt`, out, CNT_W: subtractions performed in the current or last run.

## Operation
- States: IDLE, RUN, DONE, ERR. Strobe outputs are Mealy, decoded from state, `start` and the flags. All strobes default to 0.
- IDLE:
  - `start`=1: assert `A_ld`=`B_ld`=1 with `A_sel`=`B_sel`=0, clear `iter_cnt`, go to RUN.
  - Otherwise stay.
- RUN, checked in priority order:
  1. `A_eq_B`: assert `out_ld`, go to DONE.
  2. `iter_cnt`==MAX_ITER: no strobes, go to ERR.
  3. `A_gt_B`: assert `A_sel`=1, `A_ld`=1, increment `iter_cnt`, stay.
  4. Else: assert `B_sel`=1, `B_ld`=1, increment `iter_cnt`, stay.
- DONE: `done`=1 for one cycle, then go to IDLE. `start` is ignored here.
- ERR: `err`=1, `ready`=1. `start`=1 behaves exactly like IDLE+`start` and clears `err`.
- `start` during RUN or DONE: ignored; no queuing.
- Never assert `A_ld` and `B_ld` together except in the load cycle.
- `iter_cnt` saturates at MAX_ITER and holds its value after DONE/ERR until the next accepted `start`.
- 0,0 operands: `A_eq_B` is true immediately, so the result is 0 with a normal `done`.

## Timing
- Reset: state=IDLE, `iter_cnt`=0.
  - While `rst`=1, every output is 0, including `ready`, and `start` is ignored.
  - From the first cycle after deassertion: `ready`=1, all other outputs 0.
- Reset mid-run: FSM returns to IDLE in the next cycle with no `done`/`err`. The datapath resets on the same edge.
- Latency from `start` (cycle 0) with k subtractions:
  - RUN occupies cycles 1..k+1.
  - `out_ld` is asserted in cycle k+1.
  - `done` is asserted in cycle k+2; `ready` returns in cycle k+3.
- Error run: `err` rises in cycle MAX_ITER+2.
- Back-to-back runs: earliest next `start` is the cycle after DONE (`ready`=1).
- Flags are combinational from datapath registers; the controller has no combinational path from strobes to flags.

## Structure
- Package `gcd_pkg`: state enum (IDLE/RUN/DONE/ERR), `OP_SZ_DEFAULT`=8, and function `max_iter(op_sz)`.
- Sub-module `gcd_iter_counter`: clear, increment, saturate at MAX_ITER, and `at_limit` output.
- FSM plus strobe decode live in `gcd_controller`.
- Bench drives the controller through `gcd_top`, checking `res` against a reference GCD.

## Test plan
- A=12, B=8, `start` at cycle 0:
  - A-sub in cycle 1, B-sub in cycle 2, `out_ld` in cycle 3.
  - `done` in cycle 4 with `res`=4, `iter_cnt`=2.
- A=B=7: `out_ld` in cycle 1, `done` in cycle 2 with `res`=7, `iter_cnt`=0. A=B=0 gives `res`=0 with the same timing.
- A=255, B=1: `iter_cnt`=254, `res`=1, no `err`.
- A=0, B=5 (op_sz=8):
  - `err`=1 in cycle 257, `done` never pulses, `ready`=1.
  - A following `start` with 9,6 clears `err` and returns 3.
- `start` pulsed during RUN and DONE: ignored. `rst` asserted in the middle of the 12,8 run: IDLE next cycle, no `done`, `res`=0, a fresh run returns 4.
- Random nonzero pairs, back-to-back `start` on each `ready`: every `res` equals the reference GCD, and `done` count equals accepted `start` count.
